// File: rtl/dot_product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : dot_product_accumulator
//  Description : N-lane signed dot-product engine. Lane multipliers feed a
//                balanced adder tree with a configurable register stride,
//                followed by a multi-beat accumulator with an arithmetic
//                output shift and saturation to the output width.
//  Revision    : 1.0 - initial release
// ============================================================================
module dot_product_accumulator #(
    parameter int N_LANES    = 36,
    parameter int IN_WIDTH   = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 32,
    parameter int OUT_SCALE  = 0,
    parameter int REG_STRIDE = 2
) (
    input  logic                        clk,
    input  logic                        arst_n_in,
    input  logic                        in_valid,
    input  logic                        in_first,
    input  logic                        in_last,
    input  logic [N_LANES*IN_WIDTH-1:0] I_in,
    input  logic [N_LANES*IN_WIDTH-1:0] K_in,
    output logic                        out_valid,
    output logic [OUT_WIDTH-1:0]        out,
    output logic                        sat_flag
);

    // Number of adder-tree levels; a single lane needs no tree at all.
    localparam int c_depth = $clog2(N_LANES);

    localparam logic [OUT_WIDTH-1:0] c_out_max = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] c_out_min = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    // Full-precision signed product, sign-extended to the accumulator width.
    function automatic logic [ACC_WIDTH-1:0] f_prod(
        input logic signed [IN_WIDTH-1:0] a,
        input logic signed [IN_WIDTH-1:0] b
    );
        logic signed [2*IN_WIDTH-1:0] p;
        p = (2*IN_WIDTH)'(a) * (2*IN_WIDTH)'(b);
        return ACC_WIDTH'(p);
    endfunction

    // Level 0 is the registered product row; level k halves the node count.
    // Each level exposes w_node/w_v/w_f/w_l, registered or combinational.
    for (genvar k = 0; k <= c_depth; k++) begin : g_lvl
        localparam int c_nodes = (N_LANES + (1 << k) - 1) >> k;

        logic [ACC_WIDTH-1:0] w_node [c_nodes];
        logic                 w_v;
        logic                 w_f;
        logic                 w_l;

        if (k == 0) begin : g_mul
            logic [ACC_WIDTH-1:0] r_prod [c_nodes];
            logic                 r_v;
            logic                 r_f;
            logic                 r_l;

            // Register lane products; first/last only count on valid beats.
            always_ff @(posedge clk) begin
                if (!arst_n_in) begin
                    for (int i = 0; i < c_nodes; i++) r_prod[i] <= '0;
                    r_v <= 1'b0;
                    r_f <= 1'b0;
                    r_l <= 1'b0;
                end else begin
                    for (int i = 0; i < c_nodes; i++)
                        r_prod[i] <= f_prod(I_in[i*IN_WIDTH +: IN_WIDTH],
                                            K_in[i*IN_WIDTH +: IN_WIDTH]);
                    r_v <= in_valid;
                    r_f <= in_valid & in_first;
                    r_l <= in_valid & in_last;
                end
            end

            assign w_node = r_prod;
            assign w_v    = r_v;
            assign w_f    = r_f;
            assign w_l    = r_l;
        end else begin : g_add
            localparam int c_prev = (N_LANES + (1 << (k - 1)) - 1) >> (k - 1);
            localparam bit c_reg  = ((k % REG_STRIDE) == 0) || (k == c_depth);

            logic [ACC_WIDTH-1:0] w_sum [c_nodes];

            for (genvar j = 0; j < c_nodes; j++) begin : g_node
                if (2 * j + 1 < c_prev) begin : g_pair
                    assign w_sum[j] = g_lvl[k-1].w_node[2*j] + g_lvl[k-1].w_node[2*j+1];
                end else begin : g_pass
                    // Odd element left over at this level passes through untouched.
                    assign w_sum[j] = g_lvl[k-1].w_node[2*j];
                end
            end

            if (c_reg) begin : g_reg
                logic [ACC_WIDTH-1:0] r_sum [c_nodes];
                logic                 r_v;
                logic                 r_f;
                logic                 r_l;

                // Tree pipeline register: partial sums and beat tags advance together.
                always_ff @(posedge clk) begin
                    if (!arst_n_in) begin
                        for (int i = 0; i < c_nodes; i++) r_sum[i] <= '0;
                        r_v <= 1'b0;
                        r_f <= 1'b0;
                        r_l <= 1'b0;
                    end else begin
                        for (int i = 0; i < c_nodes; i++) r_sum[i] <= w_sum[i];
                        r_v <= g_lvl[k-1].w_v;
                        r_f <= g_lvl[k-1].w_f;
                        r_l <= g_lvl[k-1].w_l;
                    end
                end

                assign w_node = r_sum;
                assign w_v    = r_v;
                assign w_f    = r_f;
                assign w_l    = r_l;
            end else begin : g_comb
                assign w_node = w_sum;
                assign w_v    = g_lvl[k-1].w_v;
                assign w_f    = g_lvl[k-1].w_f;
                assign w_l    = g_lvl[k-1].w_l;
            end
        end
    end

    logic [ACC_WIDTH-1:0]         w_sum_top;
    logic                         w_v_top;
    logic                         w_f_top;
    logic                         w_l_top;
    logic [ACC_WIDTH-1:0]         w_acc_new;
    logic [ACC_WIDTH-1:0]         w_shift;
    logic [ACC_WIDTH-OUT_WIDTH:0] w_hi;
    logic                         w_fits;
    logic [OUT_WIDTH-1:0]         w_sat_val;

    logic [ACC_WIDTH-1:0]         r_acc;
    logic [OUT_WIDTH-1:0]         r_out;
    logic                         r_out_valid;
    logic                         r_sat_flag;

    assign w_sum_top = g_lvl[c_depth].w_node[0];
    assign w_v_top   = g_lvl[c_depth].w_v;
    assign w_f_top   = g_lvl[c_depth].w_f;
    assign w_l_top   = g_lvl[c_depth].w_l;

    // A first beat restarts the sum, silently dropping any open partial sum.
    assign w_acc_new = w_f_top ? w_sum_top : (r_acc + w_sum_top);
    assign w_shift   = $signed(w_acc_new) >>> OUT_SCALE;

    // The value fits when every bit from the output sign bit upward agrees.
    assign w_hi      = w_shift[ACC_WIDTH-1:OUT_WIDTH-1];
    assign w_fits    = (&w_hi) | ~(|w_hi);
    assign w_sat_val = w_fits ? w_shift[OUT_WIDTH-1:0]
                              : (w_shift[ACC_WIDTH-1] ? c_out_min : c_out_max);

    // Accumulate valid beats; a last beat emits the result and clears the sum.
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            r_acc       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_sat_flag  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_v_top) begin
                if (w_l_top) begin
                    r_out       <= w_sat_val;
                    r_sat_flag  <= ~w_fits;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                end else begin
                    r_acc       <= w_acc_new;
                end
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign sat_flag  = r_sat_flag;

endmodule
`default_nettype wire

// File: tb/tb_dot_product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dot_product_accumulator
//  Description : Self-checking bench for dot_product_accumulator. A default
//                instance and a narrow-output clipping instance are driven
//                from a reference model that queues expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dot_product_accumulator;

    localparam int N    = 36;
    localparam int W    = 16;
    // Default instance: depth 6, stride 2 -> 3 tree stages -> latency 5.
    localparam int LAT0 = 5;
    // Clipping instance: depth 6, stride 1 -> 6 tree stages -> latency 8.
    localparam int LAT1 = 8;

    typedef struct {
        int          cyc;
        logic [31:0] val;
        logic        sat;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           vld0;
    logic           vld1;
    logic           first;
    logic           last;
    logic [N*W-1:0] I_vec;
    logic [N*W-1:0] K_vec;
    logic           ov0;
    logic           ov1;
    logic           sat0;
    logic           sat1;
    logic [31:0]    out0;
    logic [15:0]    out1;

    exp_t   sb0[$];
    exp_t   sb1[$];
    exp_t   e0;
    exp_t   e1;
    int     checks   = 0;
    int     failures = 0;
    int     cyc      = 0;
    int     nstb0    = 0;
    int     nstb1    = 0;
    longint macc[2];
    int     ia[N];
    int     ka[N];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dot_product_accumulator u_dut0 (
        .clk       (clk),
        .arst_n_in (rst_n),
        .in_valid  (vld0),
        .in_first  (first),
        .in_last   (last),
        .I_in      (I_vec),
        .K_in      (K_vec),
        .out_valid (ov0),
        .out       (out0),
        .sat_flag  (sat0)
    );

    dot_product_accumulator #(
        .ACC_WIDTH  (48),
        .OUT_WIDTH  (16),
        .OUT_SCALE  (4),
        .REG_STRIDE (1)
    ) u_dut1 (
        .clk       (clk),
        .arst_n_in (rst_n),
        .in_valid  (vld1),
        .in_first  (first),
        .in_last   (last),
        .I_in      (I_vec),
        .K_in      (K_vec),
        .out_valid (ov1),
        .out       (out1),
        .sat_flag  (sat1)
    );

    // Scoreboard: every strobe must match the oldest queued result, on its cycle.
    always @(negedge clk) begin
        if (ov0 === 1'b1) begin
            nstb0++;
            checks++;
            if (sb0.size() == 0) begin
                failures++;
                $display("FAIL dut0_stray_strobe: out_valid=1 out=%0d at cycle %0d, required no strobe", $signed(out0), cyc);
            end else begin
                e0 = sb0.pop_front();
                if (out0 !== e0.val || sat0 !== e0.sat || cyc !== e0.cyc) begin
                    failures++;
                    $display("FAIL dut0_result: out=%0d sat=%b cycle=%0d, required out=%0d sat=%b cycle=%0d",
                             $signed(out0), sat0, cyc, $signed(e0.val), e0.sat, e0.cyc);
                end
            end
        end else if (sb0.size() != 0 && sb0[0].cyc <= cyc) begin
            checks++;
            failures++;
            e0 = sb0.pop_front();
            $display("FAIL dut0_missing_strobe: out_valid=%b at cycle %0d, required strobe with out=%0d", ov0, cyc, $signed(e0.val));
        end

        if (ov1 === 1'b1) begin
            nstb1++;
            checks++;
            if (sb1.size() == 0) begin
                failures++;
                $display("FAIL dut1_stray_strobe: out_valid=1 out=%0d at cycle %0d, required no strobe", $signed(out1), cyc);
            end else begin
                e1 = sb1.pop_front();
                if (out1 !== e1.val[15:0] || sat1 !== e1.sat || cyc !== e1.cyc) begin
                    failures++;
                    $display("FAIL dut1_result: out=%0d sat=%b cycle=%0d, required out=%0d sat=%b cycle=%0d",
                             $signed(out1), sat1, cyc, $signed(e1.val[15:0]), e1.sat, e1.cyc);
                end
            end
        end else if (sb1.size() != 0 && sb1[0].cyc <= cyc) begin
            checks++;
            failures++;
            e1 = sb1.pop_front();
            $display("FAIL dut1_missing_strobe: out_valid=%b at cycle %0d, required strobe with out=%0d", ov1, cyc, $signed(e1.val[15:0]));
        end
    end

    // Sign-interpret the low w bits of x (two's-complement wrap).
    function automatic longint wrapv(input longint x, input int w);
        longint m;
        longint r;
        m = longint'(1) << w;
        r = x & (m - 1);
        if (r >= (m >>> 1)) r = r - m;
        return r;
    endfunction

    task automatic set_all(input int iv, input int kv);
        for (int i = 0; i < N; i++) begin
            ia[i] = iv;
            ka[i] = kv;
        end
    endtask

    // Present one valid beat for a cycle and queue its expected result if last.
    task automatic drive_beat(input int sel, input bit f, input bit l);
        longint s;
        longint a;
        longint q;
        longint mx;
        longint mn;
        int     accw;
        int     ow;
        int     sc;
        exp_t   e;
        accw = (sel == 0) ? 32 : 48;
        ow   = (sel == 0) ? 32 : 16;
        sc   = (sel == 0) ? 0  : 4;
        s = 0;
        for (int i = 0; i < N; i++) begin
            s += longint'(ia[i]) * longint'(ka[i]);
            I_vec[i*W +: W] = W'(ia[i]);
            K_vec[i*W +: W] = W'(ka[i]);
        end
        s = wrapv(s, accw);
        a = f ? s : wrapv(macc[sel] + s, accw);
        if (l) begin
            q     = a >>> sc;
            mx    = (longint'(1) << (ow - 1)) - 1;
            mn    = -mx - 1;
            e.sat = 1'b0;
            if (q > mx) begin
                q     = mx;
                e.sat = 1'b1;
            end else if (q < mn) begin
                q     = mn;
                e.sat = 1'b1;
            end
            e.val = 32'(q);
            e.cyc = cyc + ((sel == 0) ? LAT0 : LAT1);
            if (sel == 0) sb0.push_back(e);
            else          sb1.push_back(e);
            macc[sel] = 0;
        end else begin
            macc[sel] = a;
        end
        vld0  = (sel == 0);
        vld1  = (sel == 1);
        first = f;
        last  = l;
        @(negedge clk);
        vld0  = 1'b0;
        vld1  = 1'b0;
        first = 1'b0;
        last  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && (sb0.size() != 0 || sb1.size() != 0); i++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ov0, sat0, out0} !== 34'd0) begin
            failures++;
            $display("FAIL reset_dut0: out_valid=%b sat=%b out=%0d, required 0/0/0", ov0, sat0, out0);
        end
        checks++;
        if ({ov1, sat1, out1} !== 18'd0) begin
            failures++;
            $display("FAIL reset_dut1: out_valid=%b sat=%b out=%0d, required 0/0/0", ov1, sat1, out1);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int base;
        base = nstb0;
        set_all(1, 1);
        drive_beat(0, 1'b1, 1'b1);
        wait_drain();
        checks++;
        if (nstb0 - base !== 1) begin
            failures++;
            $display("FAIL single_count: strobes=%0d, required 1", nstb0 - base);
        end
    endtask

    task automatic test_signed();
        int base;
        base = nstb0;
        set_all(0, 0);
        ia[0]  = -3;
        ka[0]  = 2;
        ia[35] = 7;
        ka[35] = -4;
        drive_beat(0, 1'b1, 1'b1);
        wait_drain();
        checks++;
        if (nstb0 - base !== 1) begin
            failures++;
            $display("FAIL signed_count: strobes=%0d, required 1", nstb0 - base);
        end
    endtask

    task automatic test_multi_beat();
        int base;
        base = nstb0;
        set_all(1, 2);
        drive_beat(0, 1'b1, 1'b0);
        drive_beat(0, 1'b0, 1'b0);
        @(negedge clk);
        drive_beat(0, 1'b0, 1'b1);
        wait_drain();
        checks++;
        if (nstb0 - base !== 1) begin
            failures++;
            $display("FAIL multi_beat_count: strobes=%0d, required 1", nstb0 - base);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = nstb0;
        for (int v = 1; v <= 8; v++) begin
            set_all(0, 0);
            ia[0] = v;
            ka[0] = 1;
            drive_beat(0, 1'b1, 1'b1);
        end
        wait_drain();
        checks++;
        if (nstb0 - base !== 8) begin
            failures++;
            $display("FAIL back_to_back_count: strobes=%0d, required 8", nstb0 - base);
        end
    endtask

    task automatic test_boundaries();
        int base;
        base = nstb0;
        set_all(1, 1);
        drive_beat(0, 1'b1, 1'b0);          // open partial sum 36
        set_all(0, 0);
        ia[0] = 5;
        ka[0] = 1;
        drive_beat(0, 1'b1, 1'b1);          // restart drops 36 -> 5
        ia[0] = 7;
        drive_beat(0, 1'b0, 1'b1);          // no first after last -> 7
        ia[0] = 3;
        drive_beat(0, 1'b0, 1'b0);          // opens a sum without first
        set_all(9, 9);
        first = 1'b1;                        // tags on an invalid cycle are ignored
        last  = 1'b1;
        @(negedge clk);
        first = 1'b0;
        last  = 1'b0;
        set_all(0, 0);
        ia[0] = 40;
        ka[0] = 1;
        drive_beat(0, 1'b0, 1'b1);          // last without first -> 3 + 40
        wait_drain();
        checks++;
        if (nstb0 - base !== 3) begin
            failures++;
            $display("FAIL boundaries_count: strobes=%0d, required 3", nstb0 - base);
        end
    endtask

    task automatic test_wrap();
        int base;
        base = nstb0;
        set_all(32767, 32767);
        drive_beat(0, 1'b1, 1'b1);
        wait_drain();
        checks++;
        if (nstb0 - base !== 1) begin
            failures++;
            $display("FAIL wrap_count: strobes=%0d, required 1", nstb0 - base);
        end
    endtask

    task automatic test_clip();
        int base;
        base = nstb1;
        set_all(32767, 32767);
        drive_beat(1, 1'b1, 1'b1);
        set_all(32767, -32768);
        drive_beat(1, 1'b1, 1'b1);
        set_all(0, 0);
        ia[0] = 16;
        ka[0] = 16;
        drive_beat(1, 1'b1, 1'b1);
        wait_drain();
        checks++;
        if (nstb1 - base !== 3) begin
            failures++;
            $display("FAIL clip_count: strobes=%0d, required 3", nstb1 - base);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        set_all(1, 1);
        drive_beat(0, 1'b1, 1'b0);
        drive_beat(0, 1'b0, 1'b0);
        drive_beat(0, 1'b0, 1'b1);
        rst_n = 1'b0;
        sb0.delete();
        sb1.delete();
        macc[0] = 0;
        macc[1] = 0;
        @(negedge clk);
        checks++;
        if ({ov0, sat0, out0} !== 34'd0 || {ov1, sat1, out1} !== 18'd0) begin
            failures++;
            $display("FAIL reset_mid_state: dut0 ov=%b out=%0d dut1 ov=%b out=%0d, required all 0",
                     ov0, $signed(out0), ov1, $signed(out1));
        end
        rst_n = 1'b1;
        base = nstb0;
        repeat (LAT0 + 3) @(negedge clk);
        checks++;
        if (nstb0 !== base) begin
            failures++;
            $display("FAIL reset_mid_stale: strobes=%0d, required 0", nstb0 - base);
        end
        set_all(0, 0);
        ia[0] = 9;
        ka[0] = 3;
        drive_beat(0, 1'b1, 1'b1);
        wait_drain();
        checks++;
        if (nstb0 - base !== 1) begin
            failures++;
            $display("FAIL reset_mid_fresh_count: strobes=%0d, required 1", nstb0 - base);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        vld0    = 1'b0;
        vld1    = 1'b0;
        first   = 1'b0;
        last    = 1'b0;
        I_vec   = '0;
        K_vec   = '0;
        macc[0] = 0;
        macc[1] = 0;
        test_reset();
        test_single();
        test_signed();
        test_multi_beat();
        test_back_to_back();
        test_boundaries();
        test_wrap();
        test_clip();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
